// File: rtl/cpu_cmd_driver.sv
// cpu_cmd_driver: queues host control words, applies each to the CPU, and returns the captured output and flags
module cpu_cmd_driver #(
    parameter int         CMD_DEPTH = 4,
    parameter logic [5:0] IDLE_CTRL = 6'h00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [5:0]  cmd_ctrl_i,
    input  logic [3:0]  cmd_wait_i,
    output logic [7:0]  ctrl_o,
    input  logic [7:0]  cpu_out_i,
    input  logic [3:0]  cpu_flags_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [11:0] rsp_data_o,
    output logic        busy_o,
    output logic [7:0]  rsp_count_o
);
    localparam int AW = $clog2(CMD_DEPTH);
    typedef enum logic [1:0] {IDLE, SETTLE, RESPOND} state_t;
    state_t state, state_nx;
    logic [9:0] mem [CMD_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [3:0] cnt;
    logic push, pop, capture, done;
    assign cmd_ready_o = count != (AW+1)'(CMD_DEPTH);
    assign push = cmd_valid_i && cmd_ready_o;
    assign pop = state == IDLE && count != '0;
    assign capture = state == SETTLE && cnt == '0;
    assign done = state == RESPOND && rsp_ready_i;
    assign busy_o = state != IDLE || count != '0;
    always_comb begin
        state_nx = state;
        state_nx = pop ? SETTLE : capture ? RESPOND : done ? IDLE : state;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= {cmd_wait_i, cmd_ctrl_i};
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cnt         <= '0;
            ctrl_o      <= {2'b00, IDLE_CTRL};
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_count_o <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                ctrl_o <= {2'b00, mem[rd_ptr][5:0]};
                cnt    <= mem[rd_ptr][9:6];
            end
            if (state == SETTLE && cnt != '0) cnt <= cnt - 1'b1;
            if (capture) begin
                rsp_data_o  <= {cpu_flags_i, cpu_out_i};
                rsp_valid_o <= 1'b1;
                ctrl_o      <= {2'b00, IDLE_CTRL};
            end
            if (done) begin
                rsp_valid_o <= 1'b0;
                rsp_count_o <= rsp_count_o + 1'b1;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_cpu_cmd_driver.sv
// tb_cpu_cmd_driver: randomized bench against a timestamp-based transaction model of the command driver
module tb_cpu_cmd_driver;
    logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [5:0]  cmd_ctrl = '0;
    logic [3:0]  cmd_wait = '0, cpu_flags = '0;
    logic [7:0]  cpu_out = '0;
    logic        cmd_ready_o, rsp_valid_o, busy_o;
    logic [7:0]  ctrl_o, rsp_count_o;
    logic [11:0] rsp_data_o;
    int checks = 0, failures = 0, cyc = 0, hold;
    typedef struct {logic [3:0] w; logic [5:0] c;} cmd_t;
    cmd_t q[$];
    bit cur_v, rand_cpu;
    logic [5:0] cur_ctrl;
    int cur_c, last_h;
    logic [11:0] exp_data;
    logic [7:0] exp_count;

    cpu_cmd_driver dut (
        .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
        .cmd_ctrl_i(cmd_ctrl), .cmd_wait_i(cmd_wait), .ctrl_o(ctrl_o), .cpu_out_i(cpu_out),
        .cpu_flags_i(cpu_flags), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
        .rsp_data_o(rsp_data_o), .busy_o(busy_o), .rsp_count_o(rsp_count_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Command i is popped on the first edge after it is queued and after the previous handshake;
    // it captures wait+1 edges later and retires on the first later edge with ready high.
    task automatic model_edge();
        bit rdy;
        cyc++;
        if (rst) begin
            q.delete();
            cur_v = 0;
            exp_data = '0;
            exp_count = '0;
            last_h = cyc;
            return;
        end
        rdy = q.size() < 4;
        if (cur_v && cyc > cur_c && rsp_ready) begin
            cur_v = 0;
            exp_count++;
            last_h = cyc;
        end
        if (!cur_v && q.size() > 0 && cyc > last_h) begin
            cur_v = 1;
            cur_ctrl = q[0].c;
            cur_c = cyc + int'(q[0].w) + 1;
            void'(q.pop_front());
        end
        if (cur_v && cyc == cur_c) exp_data = {cpu_flags, cpu_out};
        if (cmd_valid && rdy) q.push_back('{w: cmd_wait, c: cmd_ctrl});
    endtask

    task automatic compare_all();
        logic [7:0] ec;
        ec = (cur_v && cyc < cur_c) ? {2'b00, cur_ctrl} : 8'h00;
        check("ctrl", 32'(ctrl_o), 32'(ec));
        check("rsp_valid", 32'(rsp_valid_o), 32'(cur_v && cyc >= cur_c));
        check("rsp_data", 32'(rsp_data_o), 32'(exp_data));
        check("rsp_count", 32'(rsp_count_o), 32'(exp_count));
        check("busy", 32'(busy_o), 32'(cur_v || q.size() > 0));
        check("cmd_ready", 32'(cmd_ready_o), 32'(q.size() < 4));
    endtask

    task automatic tick();
        if (rand_cpu) begin
            cpu_out = 8'($urandom);
            cpu_flags = 4'($urandom);
        end
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic push(input logic [5:0] c, input logic [3:0] w);
        bit acc = 0;
        cmd_valid = 1;
        cmd_ctrl = c;
        cmd_wait = w;
        for (int i = 0; i < 300 && !acc; i++) begin
            acc = q.size() < 4;
            tick();
        end
        cmd_valid = 0;
        check("push_accept", 32'(acc), 1);
    endtask

    task automatic wait_valid(input logic [7:0] c, output int n);
        n = 0;
        for (int i = 0; i < 100 && !rsp_valid_o; i++) begin
            tick();
            if (ctrl_o == c) n++;
        end
        check("wait_valid", 32'(rsp_valid_o), 1);
    endtask

    task automatic drain();
        cmd_valid = 0;
        rsp_ready = 1;
        for (int i = 0; i < 3000 && (cur_v || q.size() > 0); i++) tick();
        tick();
        check("drain_idle", 32'(busy_o), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge clk);
        rst = 1;
        tick();
        tick();
        rst = 0;
        check("t1_ctrl", 32'(ctrl_o), 32'h00);
        check("t1_valid", 32'(rsp_valid_o), 0);
        check("t1_ready", 32'(cmd_ready_o), 1);
        check("t1_busy", 32'(busy_o), 0);
        rand_cpu = 0;
        cpu_out = 8'hA7;
        cpu_flags = 4'b0101;
        push(6'h15, 4'd3);
        wait_valid(8'h15, hold);
        check("t2_hold", 32'(hold), 4);
        check("t2_data", 32'(rsp_data_o), 32'h5A7);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("t2_count", 32'(rsp_count_o), 1);
        check("t2_ctrl_idle", 32'(ctrl_o), 32'h00);
        cpu_out = 8'h3C;
        cpu_flags = 4'hA;
        push(6'h3F, 4'd0);
        wait_valid(8'h3F, hold);
        check("t3_hold", 32'(hold), 1);
        check("t3_data", 32'(rsp_data_o), 32'hA3C);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        rand_cpu = 1;
        for (int i = 0; i < 5; i++) push(6'(i + 1), 4'(i % 3));
        cmd_valid = 1;
        cmd_ctrl = 6'h26;
        cmd_wait = 4'd2;
        repeat (3) tick();
        check("t4_full", 32'(cmd_ready_o), 0);
        rsp_ready = 1;
        push(6'h26, 4'd2);
        drain();
        check("t4_count", 32'(rsp_count_o), 8);
        rsp_ready = 0;
        push(6'h2A, 4'd5);
        wait_valid(8'h2A, hold);
        repeat (10) tick();
        check("t5_valid", 32'(rsp_valid_o), 1);
        drain();
        for (int i = 0; i < 400; i++) begin
            cmd_valid = 1'($urandom);
            cmd_ctrl = 6'($urandom);
            cmd_wait = 4'($urandom);
            rsp_ready = $urandom_range(0, 2) != 0;
            tick();
        end
        drain();
        rsp_ready = 0;
        push(6'h11, 4'd15);
        push(6'h01, 4'd1);
        push(6'h02, 4'd2);
        repeat (2) tick();
        rst = 1;
        tick();
        rst = 0;
        check("t6_ctrl", 32'(ctrl_o), 32'h00);
        check("t6_busy", 32'(busy_o), 0);
        check("t6_valid", 32'(rsp_valid_o), 0);
        check("t6_ready", 32'(cmd_ready_o), 1);
        repeat (20) tick();
        check("t6_no_rsp", 32'(rsp_valid_o), 0);
        rsp_ready = 1;
        for (int i = 0; i < 256; i++) push(6'($urandom), 4'($urandom_range(0, 2)));
        drain();
        check("t6_wrap", 32'(rsp_count_o), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
